// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus the received-word valid/ack bundle.
// The slave modport is the receiver; master is the SPI master plus consumer.
interface spi_slave_rx_if #(
  parameter int BITS = 8
);
  logic            spi_sclk;
  logic            spi_ss_n;
  logic            spi_mosi;
  logic            spi_miso;
  logic [BITS-1:0] tx_data;
  logic [BITS-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ack;
  logic            overrun;
  logic            frame_err;
  logic            busy;

  modport slave (
    input  spi_sclk,
    input  spi_ss_n,
    input  spi_mosi,
    input  tx_data,
    input  rx_ack,
    output spi_miso,
    output rx_data,
    output rx_valid,
    output overrun,
    output frame_err,
    output busy
  );

  modport master (
    output spi_sclk,
    output spi_ss_n,
    output spi_mosi,
    output tx_data,
    output rx_ack,
    input  spi_miso,
    input  rx_data,
    input  rx_valid,
    input  overrun,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 SPI slave, MSB first, with MISO reply shifter.
// SPI lines are synchronised to CLOCK_50; words leave via valid/ack.
module spi_slave_rx #(
  parameter int BITS        = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic           CLOCK_50,
  input logic           reset_n,
  spi_slave_rx_if.slave bus
);

  localparam int            CW   = $clog2(BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES:0]   r_sclk_q;
  logic [SYNC_STAGES:0]   r_ss_q;
  logic [SYNC_STAGES-1:0] r_mosi_q;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_ss_n;
  logic w_mosi;

  logic [CW-1:0]   r_bit_cnt;
  logic [BITS-1:0] r_rx_shift;
  logic [BITS-2:0] r_tx_shift;
  logic            r_miso;
  logic            r_busy;
  logic            r_frame_err;
  logic [BITS-1:0] r_rx_data;
  logic            r_rx_valid;
  logic            r_overrun;

  logic w_done;
  logic w_take;
  logic w_ack;

  // Synchroniser chains. SS resets to "asserted" so that a frame already
  // running when reset releases never produces a spurious ss_fall.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_q <= '0;
      r_ss_q   <= '0;
      r_mosi_q <= '0;
    end else begin
      r_sclk_q <= {r_sclk_q[SYNC_STAGES-1:0], bus.spi_sclk};
      r_ss_q   <= {r_ss_q[SYNC_STAGES-1:0], bus.spi_ss_n};
      r_mosi_q <= {r_mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
    end
  end

  assign w_ss_n      = r_ss_q[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_q[SYNC_STAGES-1];
  assign w_sclk_rise = r_sclk_q[SYNC_STAGES-1] & ~r_sclk_q[SYNC_STAGES];
  assign w_sclk_fall = ~r_sclk_q[SYNC_STAGES-1] & r_sclk_q[SYNC_STAGES];
  assign w_ss_fall   = ~r_ss_q[SYNC_STAGES-1] & r_ss_q[SYNC_STAGES];
  assign w_ss_rise   = r_ss_q[SYNC_STAGES-1] & ~r_ss_q[SYNC_STAGES];

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a completed word wins over a late SS rise.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_bit_cnt == FULL) w_state_nxt = DONE;
        else if (w_ss_rise)    w_state_nxt = IDLE;
      end
      DONE: begin
        w_state_nxt = w_ss_n ? IDLE : SHIFT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter, MISO, busy and frame error.
  // Falls only shift once a bit has been sampled in the current word, so
  // the trailing fall of a word cannot disturb the reloaded reply word.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_tx_shift <= bus.tx_data[BITS-2:0];
            r_miso     <= bus.tx_data[BITS-1];
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == FULL) begin
            r_bit_cnt <= '0;
          end else if (w_ss_rise) begin
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_miso      <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[BITS-2:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + CW'(1);
            end
            if (w_sclk_fall && r_bit_cnt != '0) begin
              r_miso     <= r_tx_shift[BITS-2];
              r_tx_shift <= r_tx_shift << 1;
            end
          end
        end
        DONE: begin
          if (w_ss_n) begin
            r_busy <= 1'b0;
            r_miso <= 1'b0;
          end else begin
            r_tx_shift <= bus.tx_data[BITS-2:0];
            r_miso     <= bus.tx_data[BITS-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign w_done = (r_state == DONE);
  assign w_ack  = bus.rx_ack & r_rx_valid;
  assign w_take = w_done & (~r_rx_valid | bus.rx_ack);

  // Holding register: accept, drop with overrun, or release on ack.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_take) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_done && !w_take) begin
        r_overrun <= 1'b1;
      end else if (w_ack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.spi_miso  = r_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench acting as SPI master and word consumer.
// SCLK runs at 1 MHz (25 CLOCK_50 cycles per half period).
module tb_spi_slave_rx;

  localparam int H = 25;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;

  spi_slave_rx_if #(.BITS(8)) bus ();

  spi_slave_rx #(
    .BITS       (8),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int v_rises = 0;
  logic v_prev = 1'b0;
  logic [7:0] cap;

  always @(posedge CLOCK_50) begin
    v_prev <= bus.rx_valid;
    if (bus.rx_valid && !v_prev) v_rises <= v_rises + 1;
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    cyc(H);
    bus.spi_sclk = 1'b1;
    cap = {cap[6:0], bus.spi_miso};
    cyc(H);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) spi_bit(d[i]);
  endtask

  task automatic ss_lo();
    bus.spi_ss_n = 1'b0;
    cyc(H);
  endtask

  task automatic ss_hi();
    cyc(H);
    bus.spi_ss_n = 1'b1;
    cyc(6);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    cyc(1);
    bus.rx_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!bus.rx_valid && k < 200) begin
      cyc(1);
      k++;
    end
    chk(tag, bus.rx_valid, 1);
  endtask

  // Final bit with cycle-exact view of the DONE cycle: the word lands on
  // the 5th CLOCK_50 edge after SCLK rises; optional ack hits that edge.
  task automatic last_bit(input logic b, input bit do_ack,
                          input logic [7:0] exp);
    bus.spi_mosi = b;
    cyc(H);
    bus.spi_sclk = 1'b1;
    cap = {cap[6:0], bus.spi_miso};
    cyc(4);
    if (do_ack) bus.rx_ack = 1'b1;
    else chk("lat_early", bus.rx_valid, 0);
    cyc(1);
    bus.rx_ack = 1'b0;
    chk("lat_valid", bus.rx_valid, 1);
    chk("lat_data", bus.rx_data, exp);
    chk("lat_ovr", bus.overrun, 0);
    cyc(H - 5);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, bus.spi_miso, 0);
    chk({tag, "_data"}, bus.rx_data, 0);
    chk({tag, "_valid"}, bus.rx_valid, 0);
    chk({tag, "_ovr"}, bus.overrun, 0);
    chk({tag, "_ferr"}, bus.frame_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  logic [7:0] w66 = 8'h66;
  logic [7:0] wAA = 8'hAA;
  int fe0;
  int vr0;

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ack   = 1'b0;
    cyc(3);
    chk_reset("rst");
    reset_n = 1'b1;
    cyc(5);

    // Single word 0xAA with exact latency, then ack
    ss_lo();
    chk("aa_busy", bus.busy, 1);
    for (int i = 7; i >= 1; i--) spi_bit(wAA[i]);
    last_bit(wAA[0], 1'b0, 8'hAA);
    ss_hi();
    chk("aa_busy_off", bus.busy, 0);
    chk("aa_ferr", fe_cnt, 0);
    ack();
    chk("aa_ack", bus.rx_valid, 0);

    // Reply path
    bus.tx_data = 8'h5C;
    ss_lo();
    send_word(8'h33);
    ss_hi();
    chk("rep_miso_idle", bus.spi_miso, 0);
    wait_valid("rep_wait");
    chk("rep_data", bus.rx_data, 8'h33);
    chk("rep_cap", cap, 8'h5C);
    ack();

    // Back-to-back in one frame
    bus.tx_data = 8'hA5;
    vr0 = v_rises;
    ss_lo();
    send_word(8'hDD);
    wait_valid("b2b_w1");
    chk("b2b_d1", bus.rx_data, 8'hDD);
    chk("b2b_cap1", cap, 8'hA5);
    ack();
    chk("b2b_ack1", bus.rx_valid, 0);
    send_word(8'hEE);
    wait_valid("b2b_w2");
    chk("b2b_d2", bus.rx_data, 8'hEE);
    chk("b2b_cap2", cap, 8'hA5);
    chk("b2b_busy", bus.busy, 1);
    ack();
    ss_hi();
    chk("b2b_rises", v_rises - vr0, 2);
    chk("b2b_ovr", bus.overrun, 0);

    // Overrun
    bus.tx_data = 8'h00;
    ss_lo();
    send_word(8'h11);
    ss_hi();
    wait_valid("ovr_w1");
    ss_lo();
    send_word(8'h22);
    ss_hi();
    chk("ovr_data", bus.rx_data, 8'h11);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_valid", bus.rx_valid, 1);
    ack();
    chk("ovr_ack_v", bus.rx_valid, 0);
    chk("ovr_ack_o", bus.overrun, 0);

    // Frame error after 5 bits, then a clean word
    fe0 = fe_cnt;
    ss_lo();
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    ss_hi();
    cyc(2);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_valid", bus.rx_valid, 0);
    chk("fe_busy", bus.busy, 0);
    ss_lo();
    send_word(8'h44);
    ss_hi();
    wait_valid("fe_w44");
    chk("fe_data", bus.rx_data, 8'h44);
    ack();

    // Reset mid-frame; remainder of that frame must be ignored
    fe0 = fe_cnt;
    ss_lo();
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    reset_n = 1'b0;
    cyc(2);
    chk_reset("mid");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    chk("mid_busy", bus.busy, 0);
    chk("mid_valid", bus.rx_valid, 0);
    ss_hi();
    chk("mid_ferr", fe_cnt - fe0, 0);
    chk("mid_valid2", bus.rx_valid, 0);
    ss_lo();
    send_word(8'h55);
    ss_hi();
    wait_valid("mid_w55");
    chk("mid_data", bus.rx_data, 8'h55);

    // Completion coincident with ack while 0x55 still held
    ss_lo();
    for (int i = 7; i >= 1; i--) spi_bit(w66[i]);
    last_bit(w66[0], 1'b1, 8'h66);
    ss_hi();
    chk("coin_valid", bus.rx_valid, 1);
    chk("coin_ovr", bus.overrun, 0);
    ack();
    chk("coin_ack", bus.rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI slave receiver for the alarm-side FPGA. It consumes the MOSI/SS/SCLK lines driven by our spi_master over GPIO and synchronises them to CLOCK_50. It deserialises BITS-wide words, MSB first, and presents each word through a valid/ack holding register to the alarm logic. A reply word is shifted back on MISO, and frame and overrun errors are flagged.

Parameters:
BITS, 8, word length per transfer; matches spi_master bits_transfer.
SYNC_STAGES, 2, metastability flops on each SPI input (minimum 2).

Ports:
CLOCK_50  input  1  50 MHz system clock
reset_n  input  1  asynchronous active-low reset (driven from KEY[0])
spi_sclk  input  1  SPI clock from master, asynchronous to CLOCK_50
spi_ss_n  input  1  slave select, active low, asynchronous
spi_mosi  input  1  serial data from master, asynchronous
spi_miso  output  1  serial reply data to master
tx_data  input  BITS  reply word, sampled at frame start
rx_data  output  BITS  last received word
rx_valid  output  1  rx_data holds an unconsumed word
rx_ack  input  1  consumer pulse; clears rx_valid
overrun  output  1  sticky: word completed while rx_valid=1
frame_err  output  1  one-cycle pulse: SS deasserted mid-word
busy  output  1  high while SS asserted (LEDR indicator)

Behaviour:
- SPI mode 0: SCLK idles low; MOSI is sampled on the SCLK rising edge; MISO changes on the SCLK falling edge; MSB first.
- Input path: each SPI input passes through SYNC_STAGES flops, then one more flop for edge detection.
- A rise, fall, or ss_fall event is a single-CLOCK_50-cycle strobe from the comparison of the last two flops.
- Synchroniser latency is SYNC_STAGES+1 cycles, so SCLK is limited to at most CLOCK_50/8 (6.25 MHz). Faster SCLK is unsupported.
- Reset values: spi_miso=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, bit_cnt=0, FSM=IDLE.
- Reset is asynchronous and takes effect mid-frame. After release, the block waits in IDLE for a fresh ss_fall; any frame already in progress is ignored.
- FSM states are IDLE, SHIFT, and DONE.
  - IDLE: on ss_fall, load tx_shift<=tx_data, drive spi_miso<=tx_data[BITS-1], clear bit_cnt, set busy, go to SHIFT.
  - SHIFT: on each sclk rise, rx_shift<={rx_shift[BITS-2:0], mosi_s} and bit_cnt++.
  - SHIFT: on each sclk fall, tx_shift shifts left and spi_miso<=next MSB.
  - SHIFT: when the rise that makes bit_cnt reach BITS occurs, go to DONE the next cycle with bit_cnt reset to 0.
  - DONE (exactly 1 cycle), if rx_valid=0 or rx_ack=1 in this cycle: rx_data<=rx_shift and rx_valid<=1.
  - DONE, otherwise: the word is dropped, rx_data is unchanged, and overrun<=1.
  - DONE: return to SHIFT if SS is still asserted (back-to-back words in one frame, with tx_shift reloaded from tx_data), else go to IDLE.
- SS rise (synchronised) in SHIFT: if bit_cnt!=0, pulse frame_err for one cycle and discard the partial word. In all cases clear busy, drive spi_miso=0, and go to IDLE.
- SS rise with bit_cnt==0 is a clean end of frame with no error.
- rx_ack: clears rx_valid the next cycle and also clears overrun. rx_ack while rx_valid=0 is ignored.
- Simultaneous word completion and rx_ack: the new word is accepted, rx_valid stays 1, and overrun is not set.
- SCLK edges while in IDLE (SS high) are ignored. spi_miso is 0 whenever busy=0.
- End-to-end latency: rx_valid rises SYNC_STAGES+3 CLOCK_50 cycles after the final SCLK rising edge.

Test Plan:
- Single word: master sends 8'hAA at 1 MHz -> rx_data=8'hAA, rx_valid=1, frame_err=0, busy falls after SS rises. Then rx_ack -> rx_valid=0.
- Reply path: tx_data=8'h5C and master sends 8'h33 -> bench master captures 8'h5C on MISO while rx_data=8'h33.
- Back-to-back: one SS frame carries 8'hDD, 8'hEE with rx_ack after each -> two rx_valid rises, data DD then EE, no overrun.
- Overrun: send 8'h11, no ack, then send 8'h22 -> rx_data stays 8'h11 and overrun=1. rx_ack clears both rx_valid and overrun.
- Frame error: SS raised after 5 SCLK edges -> exactly one frame_err pulse, rx_valid stays 0. A following full 8'h44 is received correctly.
- Reset mid-frame: reset_n low after 3 bits, released while SS still low -> all outputs at reset values and the rest of that frame is ignored. Next frame 8'h55 is received correctly. Also cover completion coincident with rx_ack: rx_valid stays 1 with the new data.
